// File: rtl/mem_access_queue.sv
// mem_access_queue: in-order load/store queue driving a dual-port data memory.
// Define MEM_ACCESS_STATS_EN to add dual-issue and stall counters.
module mem_access_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid0,
  input  logic             req_valid1,
  input  logic             req_store0,
  input  logic             req_store1,
  input  logic [15:0]      req_addr0,
  input  logic [15:0]      req_addr1,
  input  logic [15:0]      req_wdata0,
  input  logic [15:0]      req_wdata1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             req_ready,
  output logic [15:0]      address0,
  output logic [15:0]      address1,
  output logic             read0,
  output logic             read1,
  output logic             write0,
  output logic             write1,
  output logic [15:0]      data_bus_write0,
  output logic [15:0]      data_bus_write1,
  input  logic [15:0]      data_bus_read0,
  input  logic [15:0]      data_bus_read1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  output logic [TAG_W-1:0] resp_tag0,
  output logic [TAG_W-1:0] resp_tag1,
  output logic [15:0]      resp_data0,
  output logic [15:0]      resp_data1
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]      stat_dual,
  output logic [15:0]      stat_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic             q_store [DEPTH];
  logic [15:0]      q_addr  [DEPTH];
  logic [15:0]      q_wdata [DEPTH];
  logic [TAG_W-1:0] q_tag   [DEPTH];
  logic [AW-1:0] head, tail, h1, slot1;
  logic [CW-1:0] count;
  logic have0, have1, st_h, st_h1, dual, acc0, acc1;
  logic [TAG_W-1:0] tag_p0, tag_p1, cap_t0, cap_t1;
  logic cap_v0, cap_v1;
  logic [15:0] cap_d0, cap_d1;
  always_comb begin
    req_ready = count <= CW'(DEPTH - 2);
    h1 = head + AW'(1);
    have0 = count != '0;
    have1 = count >= CW'(2);
    st_h = q_store[head];
    st_h1 = q_store[h1];
    // equal addresses are only safe when both are stores: write1 (younger) wins
    dual = have1 && (st_h || st_h1) && (q_addr[head] != q_addr[h1] || (st_h && st_h1));
    acc0 = req_ready && req_valid0;
    acc1 = req_ready && req_valid1;
    slot1 = acc0 ? tail + AW'(1) : tail;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(have0) + AW'(dual);
      tail <= tail + AW'(acc0) + AW'(acc1);
      count <= count + CW'(acc0) + CW'(acc1) - CW'(have0) - CW'(dual);
    end
  always_ff @(posedge clock) begin
    if (acc0) begin
      q_store[tail] <= req_store0;
      q_addr[tail] <= req_addr0;
      q_wdata[tail] <= req_wdata0;
      q_tag[tail] <= req_tag0;
    end
    if (acc1) begin
      q_store[slot1] <= req_store1;
      q_addr[slot1] <= req_addr1;
      q_wdata[slot1] <= req_wdata1;
      q_tag[slot1] <= req_tag1;
    end
  end
  // ports -> capture of read data -> response, one register stage each
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {read0, write0, read1, write1} <= '0;
      {address0, address1, data_bus_write0, data_bus_write1} <= '0;
      {tag_p0, tag_p1, cap_t0, cap_t1} <= '0;
      {cap_v0, cap_v1, cap_d0, cap_d1} <= '0;
      {resp_valid0, resp_valid1, resp_tag0, resp_tag1, resp_data0, resp_data1} <= '0;
    end else begin
      read0 <= have0 && !st_h;
      write0 <= have0 && st_h;
      address0 <= have0 ? q_addr[head] : '0;
      data_bus_write0 <= (have0 && st_h) ? q_wdata[head] : '0;
      tag_p0 <= have0 ? q_tag[head] : '0;
      read1 <= dual && !st_h1;
      write1 <= dual && st_h1;
      address1 <= dual ? q_addr[h1] : '0;
      data_bus_write1 <= (dual && st_h1) ? q_wdata[h1] : '0;
      tag_p1 <= dual ? q_tag[h1] : '0;
      cap_v0 <= read0;
      cap_v1 <= read1;
      cap_d0 <= read0 ? data_bus_read0 : '0;
      cap_d1 <= read1 ? data_bus_read1 : '0;
      cap_t0 <= read0 ? tag_p0 : '0;
      cap_t1 <= read1 ? tag_p1 : '0;
      resp_valid0 <= cap_v0;
      resp_valid1 <= cap_v1;
      resp_tag0 <= cap_t0;
      resp_tag1 <= cap_t1;
      resp_data0 <= cap_d0;
      resp_data1 <= cap_d1;
    end
`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      stat_dual <= '0;
      stat_stall <= '0;
    end else begin
      if (dual && stat_dual != '1) stat_dual <= stat_dual + 16'd1;
      if ((req_valid0 || req_valid1) && !req_ready && stat_stall != '1) stat_stall <= stat_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mem_access_queue.sv
// tb_mem_access_queue: directed stimulus with a response scoreboard and a memory model.
module tb_mem_access_queue;
  logic clock = 0, reset = 0;
  logic req_valid0 = 0, req_valid1 = 0, req_store0 = 0, req_store1 = 0;
  logic [15:0] req_addr0 = 0, req_addr1 = 0, req_wdata0 = 0, req_wdata1 = 0;
  logic [2:0] req_tag0 = 0, req_tag1 = 0;
  logic req_ready, read0, read1, write0, write1, resp_valid0, resp_valid1;
  logic [15:0] address0, address1, data_bus_write0, data_bus_write1;
  logic [15:0] data_bus_read0, data_bus_read1, resp_data0, resp_data1;
  logic [2:0] resp_tag0, resp_tag1;
  logic [15:0] mem [256];
  typedef struct {logic [2:0] tag; logic [15:0] data;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, stalls = 0;

  mem_access_queue dut (
    .clock(clock), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_store0(req_store0), .req_store1(req_store1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_tag0(req_tag0), .req_tag1(req_tag1), .req_ready(req_ready),
    .address0(address0), .address1(address1),
    .read0(read0), .read1(read1), .write0(write0), .write1(write1),
    .data_bus_write0(data_bus_write0), .data_bus_write1(data_bus_write1),
    .data_bus_read0(data_bus_read0), .data_bus_read1(data_bus_read1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_tag0(resp_tag0), .resp_tag1(resp_tag1),
    .resp_data0(resp_data0), .resp_data1(resp_data1)
  );

  always #5 clock = ~clock;

  // memory: combinational reads, write1 wins on equal addresses, word i holds i after reset
  assign data_bus_read0 = mem[address0[7:0]];
  assign data_bus_read1 = mem[address1[7:0]];
  always @(posedge clock)
    if (!reset) for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
    else begin
      if (write0) mem[address0[7:0]] <= data_bus_write0;
      if (write1) mem[address1[7:0]] <= data_bus_write1;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [2:0] tag, input logic [15:0] data);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected response tag=%0d data=%h", name, tag, data);
    end else begin
      e = sb.pop_front();
      if ({tag, data} !== {e.tag, e.data}) begin
        failures++;
        $display("FAIL %s actual tag=%0d data=%h expected tag=%0d data=%h", name, tag, data, e.tag, e.data);
      end
    end
  endtask

  always @(negedge clock)
    if (reset) begin
      if (resp_valid0) pop_cmp("resp_lane0", resp_tag0, resp_data0);
      if (resp_valid1) pop_cmp("resp_lane1", resp_tag1, resp_data1);
    end

  task automatic enq(input logic v0, input logic s0, input logic [15:0] a0, input logic [15:0] d0,
                     input logic [2:0] t0, input logic [15:0] e0,
                     input logic v1, input logic s1, input logic [15:0] a1, input logic [15:0] d1,
                     input logic [2:0] t1, input logic [15:0] e1);
    req_valid0 = v0; req_store0 = s0; req_addr0 = a0; req_wdata0 = d0; req_tag0 = t0;
    req_valid1 = v1; req_store1 = s1; req_addr1 = a1; req_wdata1 = d1; req_tag1 = t1;
    for (int k = 0; k < 20 && !req_ready; k++) begin
      stalls++;
      @(posedge clock);
      @(negedge clock);
    end
    if (!req_ready) chk("enq_timeout", 0, 1);
    if (v0 && !s0) sb.push_back('{t0, e0});
    if (v1 && !s1) sb.push_back('{t1, e1});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    req_valid0 = 0;
    req_valid1 = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clock);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_strobes", {read0, read1, write0, write1, resp_valid0, resp_valid1}, 0);
    chk("rst_bus", {address0, address1}, 0);
    chk("rst_wdata", {data_bus_write0, data_bus_write1}, 0);
    chk("rst_resp", {resp_tag0, resp_tag1, resp_data0, resp_data1}, 0);
    chk("rst_ready", req_ready, 1);
    reset = 1;
    @(negedge clock);
    // single load: ports one cycle after acceptance, response three edges after
    enq(1, 0, 16'h0002, 0, 3'd5, 16'h0002, 0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clock);
    chk("t1_read0", {read0, read1, write0, write1}, 4'b1000);
    chk("t1_addr0", address0, 16'h0002);
    @(negedge clock);
    chk("t1_read0_once", read0, 0);
    chk("t1_no_resp_early", resp_valid0, 0);
    @(negedge clock);
    chk("t1_resp", {resp_valid0, resp_tag0, resp_data0}, {1'b1, 3'd5, 16'h0002});
    // two stores to the same address issue together; younger wins
    enq(1, 1, 16'h0010, 16'h00AA, 0, 0, 1, 1, 16'h0010, 16'h00BB, 0, 0);
    idle();
    @(negedge clock);
    chk("t2_strobes", {read0, read1, write0, write1}, 4'b0011);
    chk("t2_addr", {address0, address1}, {16'h0010, 16'h0010});
    chk("t2_wdata", {data_bus_write0, data_bus_write1}, {16'h00AA, 16'h00BB});
    enq(1, 0, 16'h0010, 0, 3'd6, 16'h00BB, 0, 0, 0, 0, 0, 0);
    idle();
    // store then load to the same address must serialise
    enq(1, 1, 16'h0020, 16'h1234, 0, 0, 1, 0, 16'h0020, 0, 3'd7, 16'h1234);
    idle();
    @(negedge clock);
    chk("t3_first", {read0, read1, write0, write1}, 4'b0010);
    chk("t3_first_addr", address0, 16'h0020);
    @(negedge clock);
    chk("t3_second", {read0, read1, write0, write1}, 4'b1000);
    chk("t3_second_addr", address0, 16'h0020);
    // two loads never dual-issue
    enq(1, 0, 16'h0030, 0, 3'd1, 16'h0030, 1, 0, 16'h0031, 0, 3'd2, 16'h0031);
    idle();
    @(negedge clock);
    chk("t4_first", {read0, read1, address0}, {2'b10, 16'h0030});
    @(negedge clock);
    chk("t4_second", {read0, read1, address0}, {2'b10, 16'h0031});
    // store + load to different addresses: load rides port 1
    enq(1, 1, 16'h0040, 16'h5555, 0, 0, 1, 0, 16'h0041, 0, 3'd3, 16'h0041);
    idle();
    @(negedge clock);
    chk("t5_dual", {read0, read1, write0, write1}, 4'b0110);
    chk("t5_addr1", address1, 16'h0041);
    enq(0, 0, 0, 0, 0, 0, 1, 0, 16'h0042, 0, 3'd4, 16'h0042);
    idle();
    drain();
    // back-to-back load pairs fill the queue and wrap the pointers
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) chk("t6_ready_at_3", req_ready, 0);
      enq(1, 0, 16'(16'h0050 + 2 * i), 0, 3'(2 * i), 16'(16'h0050 + 2 * i),
          1, 0, 16'(16'h0051 + 2 * i), 0, 3'(2 * i + 1), 16'(16'h0051 + 2 * i));
    end
    idle();
    chk("t6_stalls", stalls, 4);
    drain();
    // reset with three queued entries and a load on the ports
    enq(1, 0, 16'h0060, 0, 3'd0, 16'h0060, 1, 0, 16'h0061, 0, 3'd1, 16'h0061);
    enq(1, 0, 16'h0062, 0, 3'd2, 16'h0062, 1, 0, 16'h0063, 0, 3'd3, 16'h0063);
    idle();
    chk("t7_load_on_port", {read0, address0}, {1'b1, 16'h0060});
    reset = 0;
    #1;
    chk("t7_strobes", {read0, read1, write0, write1, resp_valid0, resp_valid1}, 0);
    chk("t7_bus", {address0, resp_data0}, 0);
    chk("t7_ready", req_ready, 1);
    sb.delete();
    @(negedge clock);
    reset = 1;
    repeat (10) @(negedge clock);
    chk("t7_no_resp", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
